// File: rtl/signed_fixed_point_multiplier.sv
// Two-stage signed Qm.n multiplier: register the exact full-width product, then
// floor-rescale by the binary point and saturate into the operand format.
module signed_fixed_point_multiplier #(
    parameter int unsigned FIXED_POINT_WIDTH    = 16,
    parameter int unsigned FIXED_POINT_POSITION = 10
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [FIXED_POINT_WIDTH-1:0] multiplicand_in,
    input  logic [FIXED_POINT_WIDTH-1:0] multiplier_in,
    output logic [FIXED_POINT_WIDTH-1:0] product_out
);

    localparam int unsigned W    = FIXED_POINT_WIDTH;
    localparam int unsigned PW   = 2 * W;
    localparam int unsigned FRAC = FIXED_POINT_POSITION;
    // Bits from the result's sign bit up to the top of the shifted product
    localparam int unsigned HW   = PW - W + 1;

    logic signed [W-1:0]  a_s;
    logic signed [W-1:0]  b_s;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] shifted_c;
    logic [HW-1:0]        upper_c;
    logic                 ovf_c;
    logic [W-1:0]         sat_c;

    assign a_s = $signed(multiplicand_in);
    assign b_s = $signed(multiplier_in);

    // Operands sign-extended to full width so the product is exact
    assign prod_c = PW'(a_s) * PW'(b_s);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_c;
        end
    end

    // Arithmetic shift floors toward negative infinity; no rounding bias
    assign shifted_c = prod_q >>> FRAC;
    assign upper_c   = shifted_c[PW-1:W-1];
    assign ovf_c     = !((upper_c == '0) || (upper_c == '1));

    always_comb begin
        sat_c = shifted_c[W-1:0];
        if (ovf_c) begin
            sat_c = shifted_c[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            product_out <= '0;
        end else begin
            product_out <= sat_c;
        end
    end

endmodule

// File: tb/tb_signed_fixed_point_multiplier.sv
// Scoreboard bench for signed_fixed_point_multiplier: driver queues expected
// results, a negedge monitor pops and compares whenever a result is due.
module tb_signed_fixed_point_multiplier;

    localparam int W = 16;
    localparam int F = 10;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic [W-1:0] prod;
    logic         in_vld = 1'b0;
    logic         vld_d1;
    logic         vld_d2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } sb_t;
    sb_t sb_q[$];

    logic [W-1:0] vals [4]      = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [W-1:0] edge_exp [16] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                    16'h0000, 16'h0000, 16'h0020, 16'hFFE0,
                                    16'h0000, 16'h0020, 16'h7FFF, 16'h8000,
                                    16'h0000, 16'hFFE0, 16'h8000, 16'h7FFF};

    always #5 clk = ~clk;

    signed_fixed_point_multiplier #(
        .FIXED_POINT_WIDTH   (W),
        .FIXED_POINT_POSITION(F)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .multiplicand_in(a),
        .multiplier_in  (b),
        .product_out    (prod)
    );

    // Reference: exact integer product, floor division by 2^F, clamp to range
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        longint s;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        p = longint'($signed(x)) * longint'($signed(y));
        s = p >>> F;
        if (s > maxv) s = maxv;
        else if (s < minv) s = minv;
        return W'(s);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Tracks when a queued pair should be showing on the output
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_d1 <= 1'b0;
            vld_d2 <= 1'b0;
        end else begin
            vld_d1 <= in_vld;
            vld_d2 <= vld_d1;
        end
    end

    // Monitor: idle cycles carry zero operands, so output must be zero then
    always @(negedge clk) begin
        if (vld_d2) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: output %h with no expected entry", prod);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check($sformatf("mul %h*%h", e.a, e.b), prod, e.exp);
            end
        end else begin
            check("idle_zero", prod, '0);
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] e);
        sb_t s;
        @(negedge clk);
        a      = x;
        b      = y;
        in_vld = 1'b1;
        s.a    = x;
        s.b    = y;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a      = '0;
            b      = '0;
            in_vld = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;

        repeat (3) @(posedge clk);
        #1 check("reset_state", prod, '0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                issue(vals[i], vals[j], edge_exp[i*4+j]);
            end
        end

        issue(16'h0400, 16'h0400, 16'h0400);
        issue(16'h0200, 16'h0400, 16'h0200);
        issue(16'hFC00, 16'h0400, 16'hFC00);
        idle(2);

        for (int k = 0; k < 1000; k++) begin
            x = W'($urandom_range(1024, 0));
            y = W'($urandom_range(1024, 0));
            issue(x, y, ref_mul(x, y));
        end

        for (int k = 0; k < 1000; k++) begin
            x = W'($urandom);
            y = W'($urandom);
            issue(x, y, ref_mul(x, y));
        end

        // Reset mid-stream must clear the output without a clock edge
        repeat (3) issue(16'h0400, 16'h0400, 16'h0400);
        @(posedge clk);
        #1 check("pre_reset_out", prod, 16'h0400);
        #1;
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        in_vld = 1'b0;
        sb_q.delete();
        #1 check("async_reset", prod, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(16'h0200, 16'h0400, 16'h0200);
        @(posedge clk);
        #1 check("post_rst_edge1", prod, '0);
        idle(1);
        @(posedge clk);
        #1 check("post_rst_edge2", prod, 16'h0200);

        issue(16'h7FFF, 16'h8000, 16'h8000);
        issue(16'h8000, 16'h7FFF, 16'h8000);
        idle(4);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
